spm_cfg_sequencer: RTL and testbench
====================================

Name: spm_cfg_sequencer

Overview:
- Sits directly upstream of the scratchpad and owns its `init`, `run` and `inst` inputs.
- Accepts a host stream of scratchpad configuration words and loads them into the scratchpad configuration buffer, one word per `init` cycle.
- On command, replays a bounded number of entries by asserting `run` for exactly the requested number of cycles.
- Tracks load and replay pointers, because the scratchpad's internal counters clear only on reset; over-fill and over-run are flagged instead of issued.

Parameters:
- INST_W, `SPM_INST (24): width of one configuration word.
- DEPTH, `buffer_depth: number of entries in the scratchpad configuration buffer.
- CNT_W, $clog2(DEPTH)+1: width of the load and replay counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  host configuration word valid.
- cfg_data  in  INST_W  host configuration word.
- cfg_last  in  1  marks the final word of a load burst.
- cfg_ready  out  1  sequencer accepts cfg_data this cycle.
- start  in  1  replay request, single-cycle pulse.
- run_len  in  CNT_W  number of entries to replay; sampled when start is accepted.
- busy  out  1  high while in LOAD or RUN.
- done  out  1  one-cycle pulse at the end of a load burst or a replay.
- err  out  1  sticky error flag; cleared only by rst.
- err_code  out  2  01 = over-fill, 10 = over-run, 11 = start while busy.
- spm_init  out  1  drives the scratchpad `init` input.
- spm_run  out  1  drives the scratchpad `run` input.
- spm_inst  out  INST_W  drives the scratchpad `inst` input.
- loaded_cnt  out  CNT_W  number of words written since reset.
- run_ptr  out  CNT_W  number of entries replayed since reset.

Behaviour:
- Reset: on rst, all outputs are 0, the state is IDLE, and loaded_cnt and run_ptr are 0. Pointers clear only on rst, to stay aligned with the scratchpad's internal counters; the integrator asserts the same rst to both blocks.
- All outputs are registered. spm_init, spm_run and spm_inst change only on a clk edge.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cfg_ready = 1 when loaded_cnt < DEPTH.
  - A handshake (cfg_valid & cfg_ready) moves to LOAD and issues the first word.
  - start with cfg_valid low moves to RUN if the request is legal.
  - If start and cfg_valid are both high in the same cycle, the load wins and start is dropped. err is not set.
- LOAD:
  - Each handshake registers spm_inst = cfg_data and spm_init = 1 on the next edge; loaded_cnt increments. Latency from handshake to spm_init high is 1 cycle.
  - A cycle with no handshake drives spm_init = 0. spm_inst holds its value.
  - A handshake with cfg_last = 1 moves to DONE.
  - When loaded_cnt reaches DEPTH, cfg_ready drops to 0.
  - If cfg_valid is held while loaded_cnt == DEPTH, err is set with code 01, the state moves to DONE, and the word is discarded.
- RUN:
  - start is legal only when run_len != 0 and run_len <= loaded_cnt - run_ptr.
  - An illegal request sets err with code 10 and stays in IDLE; spm_run never asserts.
  - A legal request asserts spm_run for exactly run_len consecutive cycles, starting the cycle after start. run_ptr increments once per spm_run cycle.
  - cfg_ready = 0 throughout RUN; a start received during RUN sets err with code 11 and is otherwise ignored.
  - After the last spm_run cycle, the state moves to DONE.
- DONE: done = 1 for one cycle, then IDLE. busy is 0 in IDLE and DONE.
- spm_init and spm_run are never high in the same cycle.
- A second or later load burst appends: the scratchpad write pointer continues from loaded_cnt.
- A later replay continues from run_ptr. Entries are not rewound without rst.
- Reset asserted mid-LOAD or mid-RUN: the next cycle shows IDLE, all outputs 0, and no residual spm_init or spm_run pulse.
- Counter arithmetic is unsigned CNT_W. loaded_cnt - run_ptr is never negative by construction.

Decomposition:
- Shared package / include file: existing `SPM_INST and `buffer_depth, plus new defines for the FSM state encoding (2 bits) and the err_code values.
- One natural sub-module, spm_cfg_ctr: a saturating up-counter with enable, limit and at_limit output. Instantiate it twice, once for loaded_cnt and once for run_ptr.

Test Plan:
1. Reset, then stream 3 words (0x000111, 0x000222, 0x000333 with last) back-to-back. Required: spm_init high for 3 consecutive cycles with spm_inst matching, loaded_cnt = 3, done pulses once, busy returns to 0.
2. After test 1, start with run_len = 2. Required: spm_run high exactly 2 cycles starting 1 cycle after start, run_ptr = 2, done pulse. Then start with run_len = 2 again. Required: err = 1, err_code = 10, no spm_run.
3. Load DEPTH words, then present one more word. Required: cfg_ready = 0 at loaded_cnt = DEPTH, err_code = 01, spm_init count = DEPTH.
4. start and cfg_valid asserted in the same IDLE cycle. Required: load proceeds, start is dropped, err stays 0. Then pulse start during a run_len = 4 replay. Required: err_code = 11 and the replay still completes 4 cycles.
5. Assert rst for 1 cycle on the 2nd cycle of a run_len = 5 replay. Required: the next cycle has spm_run = 0, state IDLE, and loaded_cnt, run_ptr, err all 0.
6. Stream 4 words with cfg_valid toggled every other cycle. Required: spm_init gaps mirror the handshake gaps, and spm_inst holds its value during gaps.

Source files
------------

// File: rtl/spm_cfg_sequencer_pkg.sv
// Shared types and constants for the scratchpad configuration sequencer.
// Holds word width, buffer depth, FSM state encoding and error codes.
package spm_cfg_sequencer_pkg;

    localparam int SPM_INST     = 24;
    localparam int BUFFER_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } seq_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVERFILL = 2'b01;
    localparam logic [1:0] ERR_OVERRUN  = 2'b10;
    localparam logic [1:0] ERR_BUSY     = 2'b11;

    function automatic logic state_is_busy(input seq_state_e st);
        return (st == ST_LOAD) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/spm_cfg_sequencer_ctr.sv
// Saturating up-counter with enable; stops at limit and flags when it is there.
// Used for both the load pointer and the replay pointer.
module spm_cfg_ctr
    import spm_cfg_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: advance only when enabled and below the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != limit)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/spm_cfg_sequencer.sv
// Loads host configuration words into the scratchpad buffer and replays them,
// keeping load/replay pointers aligned with the scratchpad's own counters.
module spm_cfg_sequencer
    import spm_cfg_sequencer_pkg::*;
#(
    parameter int INST_W = SPM_INST,
    parameter int DEPTH  = BUFFER_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [INST_W-1:0] cfg_data,
    input  logic              cfg_last,
    output logic              cfg_ready,
    input  logic              start,
    input  logic [CNT_W-1:0]  run_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              spm_init,
    output logic              spm_run,
    output logic [INST_W-1:0] spm_inst,
    output logic [CNT_W-1:0]  loaded_cnt,
    output logic [CNT_W-1:0]  run_ptr
);

    seq_state_e        state_q, state_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              spm_init_q, spm_init_d;
    logic              spm_run_q, spm_run_d;
    logic [INST_W-1:0] spm_inst_q, spm_inst_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;

    logic              hs_s;
    logic              loaded_full_s;
    logic              run_exhausted_s;
    logic [CNT_W-1:0]  avail_s;
    logic              run_legal_s;
    logic [CNT_W-1:0]  loaded_nxt_s;

    spm_cfg_ctr #(.CNT_W(CNT_W)) u_load_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (spm_init_d),
        .limit    (CNT_W'(DEPTH)),
        .cnt      (loaded_cnt),
        .at_limit (loaded_full_s)
    );

    // The replay pointer can never pass what has been loaded.
    spm_cfg_ctr #(.CNT_W(CNT_W)) u_run_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (spm_run_d),
        .limit    (loaded_cnt),
        .cnt      (run_ptr),
        .at_limit (run_exhausted_s)
    );

    assign hs_s        = cfg_valid & cfg_ready_q;
    assign avail_s     = loaded_cnt - run_ptr;
    assign run_legal_s = (run_len != '0) && !run_exhausted_s && (run_len <= avail_s);

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        spm_init_d  = 1'b0;
        spm_run_d   = 1'b0;
        spm_inst_d  = spm_inst_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (hs_s) begin
                        spm_init_d = 1'b1;
                        spm_inst_d = cfg_data;
                        state_d    = cfg_last ? ST_DONE : ST_LOAD;
                    end else if (loaded_full_s) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERFILL;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (start) begin
                    if (run_legal_s) begin
                        spm_run_d   = 1'b1;
                        remaining_d = run_len - CNT_W'(1);
                        state_d     = ST_RUN;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERRUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BUSY;
                end else begin
                    err_d = err_q;
                end
                if (hs_s) begin
                    spm_init_d = 1'b1;
                    spm_inst_d = cfg_data;
                    state_d    = cfg_last ? ST_DONE : ST_LOAD;
                end else if (cfg_valid && loaded_full_s) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERFILL;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (start) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BUSY;
                end else begin
                    err_d = err_q;
                end
                if (remaining_q != '0) begin
                    spm_run_d   = 1'b1;
                    remaining_d = remaining_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        loaded_nxt_s = loaded_cnt + CNT_W'(spm_init_d);
        cfg_ready_d  = ((state_d == ST_IDLE) || (state_d == ST_LOAD)) &&
                       (loaded_nxt_s < CNT_W'(DEPTH));
        busy_d       = state_is_busy(state_d);
        done_d       = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            spm_init_q  <= 1'b0;
            spm_run_q   <= 1'b0;
            spm_inst_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            spm_init_q  <= spm_init_d;
            spm_run_q   <= spm_run_d;
            spm_inst_q  <= spm_inst_d;
            remaining_q <= remaining_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign spm_init  = spm_init_q;
    assign spm_run   = spm_run_q;
    assign spm_inst  = spm_inst_q;

endmodule

// File: tb/tb_spm_cfg_sequencer.sv
// Scoreboard bench for spm_cfg_sequencer: expected init words are queued at
// handshake time and popped as spm_init appears.
module tb_spm_cfg_sequencer;
    import spm_cfg_sequencer_pkg::*;

    localparam int INST_W = SPM_INST;
    localparam int DEPTH  = BUFFER_DEPTH;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [INST_W-1:0] cfg_data;
    logic              cfg_last;
    logic              cfg_ready;
    logic              start;
    logic [CNT_W-1:0]  run_len;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic              spm_init;
    logic              spm_run;
    logic [INST_W-1:0] spm_inst;
    logic [CNT_W-1:0]  loaded_cnt;
    logic [CNT_W-1:0]  run_ptr;

    int n_tests = 0;
    int n_fail  = 0;
    int init_cnt, run_cnt, done_cnt, cyc;
    logic [INST_W-1:0] last_inst;
    logic [INST_W-1:0] exp_q[$];

    spm_cfg_sequencer dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_last(cfg_last), .cfg_ready(cfg_ready), .start(start), .run_len(run_len),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .spm_init(spm_init), .spm_run(spm_run), .spm_inst(spm_inst),
        .loaded_cnt(loaded_cnt), .run_ptr(run_ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock, then scoreboard and monitor checks on the settled outputs.
    task automatic tick();
        logic [INST_W-1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        n_tests++;
        if ((spm_init & spm_run) !== 1'b0) begin
            n_fail++;
            $display("FAIL init_run_excl: init=%b run=%b, required not both high", spm_init, spm_run);
        end
        if (spm_init) begin
            init_cnt++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_init: spm_inst=%h, no word expected", spm_inst);
            end else begin
                e = exp_q.pop_front();
                if (spm_inst !== e) begin
                    n_fail++;
                    $display("FAIL sb_inst: got %h, required %h", spm_inst, e);
                end
            end
            last_inst = spm_inst;
        end else begin
            n_tests++;
            if (spm_inst !== last_inst) begin
                n_fail++;
                $display("FAIL inst_hold: got %h, required %h", spm_inst, last_inst);
            end
        end
        if (spm_run) run_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; cfg_last = 1'b0;
        exp_q.delete();
        last_inst = '0;
        tick();
        rst = 1'b0;
        tick();
        init_cnt = 0; run_cnt = 0; done_cnt = 0;
    endtask

    task automatic send_word(input logic [INST_W-1:0] d, input logic l);
        bit ok = 1'b0;
        cfg_valid = 1'b1; cfg_data = d; cfg_last = l;
        for (int i = 0; i < 20; i++) begin
            if (cfg_ready) begin
                exp_q.push_back(d);
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: cfg_ready=%b, required 1 within 20 cycles", cfg_ready);
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 100; i++) begin
            if (done_cnt >= target) break;
            tick();
        end
        n_tests++;
        if (done_cnt < target) begin
            n_fail++;
            $display("FAIL done_timeout: done pulses=%0d, required %0d", done_cnt, target);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; cfg_last = 1'b0;
        cfg_data = '0; run_len = '0; last_inst = '0;
        tick(); tick();
        n_tests++;
        if ({cfg_ready, busy, done, err, err_code, spm_init, spm_run, spm_inst, loaded_cnt, run_ptr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b err=%b code=%b init=%b run=%b inst=%h ld=%0d rp=%0d, required all 0",
                     cfg_ready, busy, done, err, err_code, spm_init, spm_run, spm_inst, loaded_cnt, run_ptr);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: ready=%b busy=%b, required 1/0", cfg_ready, busy);
        end
        init_cnt = 0; run_cnt = 0; done_cnt = 0;
    endtask

    task automatic test_load_burst();
        int c0;
        c0 = cyc;
        send_word(24'h000111, 1'b0);
        send_word(24'h000222, 1'b0);
        send_word(24'h000333, 1'b1);
        cfg_valid = 1'b0; cfg_last = 1'b0;
        n_tests++;
        if (cyc - c0 != 3 || init_cnt != 3) begin
            n_fail++;
            $display("FAIL burst_consec: cycles=%0d inits=%0d, required 3/3", cyc - c0, init_cnt);
        end
        wait_done(1);
        n_tests++;
        if (loaded_cnt !== CNT_W'(3) || done_cnt != 1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: ld=%0d done_pulses=%0d busy=%b done=%b, required 3/1/0/0",
                     loaded_cnt, done_cnt, busy, done);
        end
    endtask

    task automatic test_replay();
        start = 1'b1; run_len = CNT_W'(2);
        tick();
        start = 1'b0;
        n_tests++;
        if (spm_run !== 1'b1) begin
            n_fail++;
            $display("FAIL run_latency: spm_run=%b one cycle after start, required 1", spm_run);
        end
        wait_done(2);
        n_tests++;
        if (run_cnt != 2 || run_ptr !== CNT_W'(2) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL run_len2: run cycles=%0d rp=%0d err=%b, required 2/2/0", run_cnt, run_ptr, err);
        end
        start = 1'b1; run_len = CNT_W'(2);
        tick();
        start = 1'b0;
        tick(); tick();
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'b10 || run_cnt != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun: err=%b code=%b run cycles=%0d busy=%b, required 1/10/2/0",
                     err, err_code, run_cnt, busy);
        end
    endtask

    task automatic test_overfill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send_word(24'hA00 + 24'(i), 1'b0);
        end
        cfg_data = 24'hBADBAD;
        n_tests++;
        if (cfg_ready !== 1'b0 || loaded_cnt !== CNT_W'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_ready: ready=%b ld=%0d, required 0/%0d", cfg_ready, loaded_cnt, DEPTH);
        end
        tick();
        cfg_valid = 1'b0;
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'b01 || spm_init !== 1'b0 || init_cnt != DEPTH || done !== 1'b1) begin
            n_fail++;
            $display("FAIL overfill: err=%b code=%b init=%b inits=%0d done=%b, required 1/01/0/%0d/1",
                     err, err_code, spm_init, init_cnt, done, DEPTH);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        start = 1'b1; run_len = CNT_W'(1);
        send_word(24'h000444, 1'b0);
        start = 1'b0;
        send_word(24'h000555, 1'b0);
        send_word(24'h000666, 1'b0);
        send_word(24'h000777, 1'b1);
        cfg_valid = 1'b0; cfg_last = 1'b0;
        wait_done(1);
        n_tests++;
        if (err !== 1'b0 || loaded_cnt !== CNT_W'(4) || run_cnt != 0) begin
            n_fail++;
            $display("FAIL load_wins: err=%b ld=%0d run cycles=%0d, required 0/4/0", err, loaded_cnt, run_cnt);
        end
        start = 1'b1; run_len = CNT_W'(4);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'b11 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: err=%b code=%b busy=%b, required 1/11/1", err, err_code, busy);
        end
        wait_done(2);
        n_tests++;
        if (run_cnt != 4 || run_ptr !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL run_len4: run cycles=%0d rp=%0d, required 4/4", run_cnt, run_ptr);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_word(24'h00B000 + 24'(i), (i == 4));
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        wait_done(1);
        run_cnt = 0;
        start = 1'b1; run_len = CNT_W'(5);
        tick();
        start = 1'b0;
        tick();
        n_tests++;
        if (spm_run !== 1'b1) begin
            n_fail++;
            $display("FAIL run_second: spm_run=%b, required 1", spm_run);
        end
        rst = 1'b1;
        last_inst = '0;
        exp_q.delete();
        tick();
        n_tests++;
        if (spm_run !== 1'b0 || busy !== 1'b0 || loaded_cnt !== '0 || run_ptr !== '0 || err !== 1'b0 || run_cnt != 2) begin
            n_fail++;
            $display("FAIL mid_run_reset: run=%b busy=%b ld=%0d rp=%0d err=%b run cycles=%0d, required 0/0/0/0/0/2",
                     spm_run, busy, loaded_cnt, run_ptr, err, run_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_gapped_load();
        logic [INST_W-1:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d = 24'h0C0000 + 24'(i * 3 + 1);
            send_word(d, (i == 3));
            cfg_valid = 1'b0;
            tick();
            n_tests++;
            if (spm_init !== 1'b0 || spm_inst !== d) begin
                n_fail++;
                $display("FAIL gap_hold: init=%b inst=%h, required 0/%h", spm_init, spm_inst, d);
            end
        end
        cfg_last = 1'b0;
        tick();
        n_tests++;
        if (init_cnt != 4 || exp_q.size() != 0 || loaded_cnt !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL gapped_total: inits=%0d pending=%0d ld=%0d, required 4/0/4",
                     init_cnt, exp_q.size(), loaded_cnt);
        end
    endtask

    initial begin
        cyc = 0; init_cnt = 0; run_cnt = 0; done_cnt = 0;
        test_reset();
        test_load_burst();
        test_replay();
        test_overfill();
        test_back_to_back();
        test_reset_mid_run();
        test_gapped_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
